busqueda_param: RTL

//  Parametrised motion-estimation search FSM between the reference and current frame RAMs, feeding the HPS FIFOs.
//  For each reference pixel in the window, scans current-frame pixels within a bounded search range.

---
 rtl/busqueda_param_if.sv | 31 +++
 rtl/busqueda_param.sv | 122 ++++++++++++
 2 files changed

// File: rtl/busqueda_param_if.sv
// busqueda_param_if: FIFO push ports and ref/act frame-RAM ports of the motion search FSM
interface busqueda_param_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W = 24,
  parameter int FRAME_W = 2
);
  logic vector_wait_fifo;
  logic vector_wr_req;
  logic [FRAME_W+2*ADDR_W-1:0] vector_me;
  logic img_wait_fifo;
  logic img_wr_req;
  logic [FRAME_W+PIX_W-1:0] img_mb;
  logic [ADDR_W-1:0] add_img_ref;
  logic [ADDR_W-1:0] add_img_act;
  logic [PIX_W:0] data_rd_img_ref;
  logic [PIX_W:0] data_wr_img_ref;
  logic [PIX_W:0] data_rd_img_act;
  logic [PIX_W:0] data_wr_img_act;
  logic wr_enable_ref;
  logic wr_enable_act;
  modport master (
    input vector_wait_fifo, img_wait_fifo, data_rd_img_ref, data_rd_img_act,
    output vector_wr_req, vector_me, img_wr_req, img_mb, add_img_ref, data_wr_img_ref,
           wr_enable_ref, add_img_act, data_wr_img_act, wr_enable_act
  );
  modport slave (
    output vector_wait_fifo, img_wait_fifo, data_rd_img_ref, data_rd_img_act,
    input vector_wr_req, vector_me, img_wr_req, img_mb, add_img_ref, data_wr_img_ref,
          wr_enable_ref, add_img_act, data_wr_img_act, wr_enable_act
  );
endinterface

// File: rtl/busqueda_param.sv
// busqueda_param: motion-estimation search FSM over ref/act frame RAMs feeding vector and image FIFOs.
// Define STATS_EN to enable the vec_count/miss_count statistics counters.
module busqueda_param #(
  parameter int ADDR_W = 14,
  parameter int PIX_W = 24,
  parameter int CMP_LSB = 0,
  parameter int CMP_W = 8,
  parameter int FRAME_W = 2
) (
  input  logic clk_fsm,
  input  logic rst,
  input  logic start,
  output logic finish,
  output logic idle,
  input  logic [FRAME_W-1:0] cont_img,
  input  logic [ADDR_W-1:0] window_limit,
  input  logic [ADDR_W-1:0] search_range,
  input  logic [CMP_W-1:0] match_tol,
  output logic [3:0] real_state,
  output logic [ADDR_W:0] vec_count,
  output logic [ADDR_W:0] miss_count,
  busqueda_param_if.master bus
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, RD = 4'd1, CMP = 4'd2, VEC = 4'd3, MARK2 = 4'd4, MARK1 = 4'd5,
    NXT = 4'd6, DRST = 4'd7, DRD = 4'd8, DWR = 4'd9, DONE = 4'd10
  } state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] ref_q, act_q, n_q, r_q;
  logic [CMP_W-1:0] t_q;
  logic [FRAME_W-1:0] frame_q;
  logic [CMP_W:0] diff, mag;
  logic [ADDR_W:0] sum, n_m1, end_v, ref_p1;
  logic ref_vis, act_vis, match, act_lt_end, go;
  assign go = state == IDLE && start;
  assign ref_vis = bus.data_rd_img_ref[PIX_W];
  assign act_vis = bus.data_rd_img_act[PIX_W];
  assign diff = {1'b0, bus.data_rd_img_ref[CMP_LSB +: CMP_W]} - {1'b0, bus.data_rd_img_act[CMP_LSB +: CMP_W]};
  assign mag = diff[CMP_W] ? -diff : diff;
  assign match = !act_vis && mag <= {1'b0, t_q};
  // scan end is clipped to the last window pixel at one extra bit so ref+R never wraps
  assign sum = {1'b0, ref_q} + {1'b0, r_q};
  assign n_m1 = {1'b0, n_q} - (ADDR_W+1)'(1);
  assign end_v = sum < n_m1 ? sum : n_m1;
  assign act_lt_end = {1'b0, act_q} < end_v;
  assign ref_p1 = {1'b0, ref_q} + (ADDR_W+1)'(1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? (window_limit == '0 ? DONE : RD) : IDLE;
      RD:    state_n = CMP;
      CMP:   state_n = ref_vis ? NXT : match ? (act_q == ref_q ? MARK2 : VEC) : act_lt_end ? RD : MARK1;
      VEC:   state_n = bus.vector_wait_fifo ? VEC : MARK2;
      MARK2: state_n = NXT;
      MARK1: state_n = NXT;
      NXT:   state_n = ref_p1 >= {1'b0, n_q} ? DRST : RD;
      DRST:  state_n = DRD;
      DRD:   state_n = ref_q >= n_q ? DONE : DWR;
      DWR:   state_n = bus.img_wait_fifo ? DWR : DRD;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      state <= IDLE;
      ref_q <= '0;
      act_q <= '0;
      n_q <= '0;
      r_q <= '0;
      t_q <= '0;
      frame_q <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        ref_q <= '0;
        act_q <= '0;
        n_q <= window_limit;
        r_q <= search_range;
        t_q <= match_tol;
        frame_q <= cont_img;
      end
      if (state == CMP && state_n == RD) act_q <= act_q + ADDR_W'(1);
      if (state == NXT) begin
        ref_q <= ref_p1[ADDR_W-1:0];
        act_q <= ref_p1[ADDR_W-1:0];
      end
      if (state == DRST) ref_q <= '0;
      if (bus.img_wr_req) ref_q <= ref_q + ADDR_W'(1);
    end
  end
  assign idle = state == IDLE;
  assign finish = state == DONE;
  assign real_state = state;
  assign bus.vector_wr_req = state == VEC && !bus.vector_wait_fifo;
  assign bus.vector_me = {frame_q, ref_q, act_q};
  assign bus.img_wr_req = state == DWR && !bus.img_wait_fifo;
  assign bus.img_mb = {frame_q, bus.data_rd_img_ref[PIX_W-1:0]};
  assign bus.add_img_ref = ref_q;
  assign bus.add_img_act = act_q;
  assign bus.data_wr_img_ref = {1'b1, bus.data_rd_img_ref[PIX_W-1:0]};
  assign bus.data_wr_img_act = {1'b1, bus.data_rd_img_act[PIX_W-1:0]};
  assign bus.wr_enable_ref = state == MARK2 || state == MARK1;
  assign bus.wr_enable_act = state == MARK2;
`ifdef STATS_EN
  logic [ADDR_W:0] vec_c, miss_c;
  always_ff @(posedge clk_fsm) begin
    if (rst || go) begin
      vec_c <= '0;
      miss_c <= '0;
    end else begin
      if (bus.vector_wr_req) vec_c <= vec_c + (ADDR_W+1)'(1);
      if (state == MARK1) miss_c <= miss_c + (ADDR_W+1)'(1);
    end
  end
  assign vec_count = vec_c;
  assign miss_count = miss_c;
`else
  assign vec_count = '0;
  assign miss_count = '0;
`endif
endmodule
